// File: rtl/sqrwav_gen_prog_if.sv
// Control/status bundle for sqrwav_gen_prog: run/load requests and M/N/burst
// settings in, wave and status flags out.
interface sqrwav_gen_prog_if #(
    parameter int unsigned W = 8
);
    logic         en;
    logic         load;
    logic [W-1:0] m;
    logic [W-1:0] n;
    logic [7:0]   burst_len;
    logic         wave_out;
    logic         period_done;
    logic         busy;
    logic         done;

    modport master (
        output en, load, m, n, burst_len,
        input  wave_out, period_done, busy, done
    );

    modport slave (
        input  en, load, m, n, burst_len,
        output wave_out, period_done, busy, done
    );
endinterface

// File: rtl/sqrwav_gen_prog.sv
// Programmable square-wave generator: M ticks high, N ticks low, tick = PRESCALE clocks.
// Define SQRWAV_BURST_EN to build the burst mode (DONE state, period counter).
module sqrwav_gen_prog #(
    parameter int unsigned W        = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst,
    sqrwav_gen_prog_if.slave   bus
);

`ifdef SQRWAV_BURST_EN
    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
`endif

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    state_t       state, state_d;
    logic [W-1:0] m_act, n_act, m_pnd, n_pnd, phase;
    logic [W-1:0] m_act_d, n_act_d, m_pnd_d, n_pnd_d, phase_d;
    logic [W-1:0] m_new, n_new, phase_len, len_d;
    logic [15:0]  pre, pre_d;
    logic         pend, pend_d;
    logic         period_end, launch;
    logic         wave_q, pd_q, busy_q;
    logic         wave_d, pd_d, busy_d;
`ifdef SQRWAV_BURST_EN
    logic [7:0]   per_cnt, per_d, blen, blen_d;
    logic         done_q, done_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            m_act  <= '0;
            n_act  <= '0;
            m_pnd  <= '0;
            n_pnd  <= '0;
            pend   <= 1'b0;
            phase  <= '0;
            pre    <= '0;
            wave_q <= 1'b0;
            pd_q   <= 1'b0;
            busy_q <= 1'b0;
`ifdef SQRWAV_BURST_EN
            per_cnt <= '0;
            blen    <= '0;
            done_q  <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            m_act  <= m_act_d;
            n_act  <= n_act_d;
            m_pnd  <= m_pnd_d;
            n_pnd  <= n_pnd_d;
            pend   <= pend_d;
            phase  <= phase_d;
            pre    <= pre_d;
            wave_q <= wave_d;
            pd_q   <= pd_d;
            busy_q <= busy_d;
`ifdef SQRWAV_BURST_EN
            per_cnt <= per_d;
            blen    <= blen_d;
            done_q  <= done_d;
`endif
        end
    end

    always_comb begin
        state_d    = state;
        m_act_d    = m_act;
        n_act_d    = n_act;
        m_pnd_d    = m_pnd;
        n_pnd_d    = n_pnd;
        pend_d     = pend;
        phase_d    = phase;
        pre_d      = pre;
        period_end = 1'b0;
        launch     = 1'b0;
`ifdef SQRWAV_BURST_EN
        per_d  = per_cnt;
        blen_d = blen;
`endif
        // Values for a period starting at this edge; a same-cycle load wins.
        m_new     = bus.load ? bus.m : (pend ? m_pnd : m_act);
        n_new     = bus.load ? bus.n : (pend ? n_pnd : n_act);
        phase_len = (state == HIGH) ? m_act : n_act;

        if (bus.load) begin
            m_pnd_d = bus.m;
            n_pnd_d = bus.n;
            pend_d  = 1'b1;
        end

        unique case (state)
            IDLE: begin
                m_act_d = m_new;
                n_act_d = n_new;
                pend_d  = 1'b0;
                launch  = bus.en && ((m_new != '0) || (n_new != '0));
`ifdef SQRWAV_BURST_EN
                if (launch) begin
                    per_d  = 8'd1;
                    blen_d = bus.burst_len;
                end
`endif
            end
            HIGH, LOW: begin
                if (pre != PS_LAST) begin
                    pre_d = pre + 16'd1;
                end else begin
                    pre_d = '0;
                    if (phase != phase_len - W'(1)) begin
                        phase_d = phase + W'(1);
                    end else begin
                        phase_d = '0;
                        if (state == HIGH && n_act != '0) state_d = LOW;
                        else period_end = 1'b1;
                    end
                end
            end
`ifdef SQRWAV_BURST_EN
            DONE: if (!bus.en) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        if (period_end) begin
`ifdef SQRWAV_BURST_EN
            if (blen != 8'd0 && per_cnt == blen) state_d = DONE;
            else
`endif
            if (!bus.en || ((m_new == '0) && (n_new == '0))) begin
                state_d = IDLE;
            end else begin
                launch = 1'b1;
`ifdef SQRWAV_BURST_EN
                per_d = per_cnt + 8'd1;
`endif
            end
        end

        if (launch) begin
            m_act_d = m_new;
            n_act_d = n_new;
            pend_d  = 1'b0;
            state_d = (m_new != '0) ? HIGH : LOW;
            pre_d   = '0;
            phase_d = '0;
        end

        // Outputs are registered, so flag the last period cycle from the next-state values.
        len_d  = (state_d == HIGH) ? m_act_d : n_act_d;
        wave_d = (state_d == HIGH);
        busy_d = (state_d == HIGH) || (state_d == LOW);
        pd_d   = (pre_d == PS_LAST) && (phase_d == len_d - W'(1)) &&
                 ((state_d == LOW) || ((state_d == HIGH) && (n_act_d == '0)));
`ifdef SQRWAV_BURST_EN
        done_d = (state_d == DONE);
`endif
    end

    assign bus.wave_out    = wave_q;
    assign bus.period_done = pd_q;
    assign bus.busy        = busy_q;
`ifdef SQRWAV_BURST_EN
    assign bus.done        = done_q;
`else
    assign bus.done        = 1'b0;
`endif

endmodule

// File: tb/tb_sqrwav_gen_prog.sv
// Scoreboard bench for sqrwav_gen_prog: two instances (PRESCALE 1 and 4), directed
// vectors push per-cycle expectations {wave,pd,busy,done}; a monitor pops and compares.
module tb_sqrwav_gen_prog;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sqrwav_gen_prog_if #(.W(8)) bus0 ();
    sqrwav_gen_prog_if #(.W(8)) bus1 ();

    sqrwav_gen_prog #(.W(8), .PRESCALE(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sqrwav_gen_prog #(.W(8), .PRESCALE(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        string      name;
        logic [3:0] e0, k0, e1, k1;
    } exp_t;

    exp_t  sbq[$];
    int    vectors     = 0;
    int    miscompares = 0;
    string tag         = "reset";

    task automatic check(input string name, input int u, input logic [3:0] got,
                         input logic [3:0] want, input logic [3:0] msk);
        if (msk != 4'h0) begin
            vectors++;
            if ((got & msk) !== (want & msk)) begin
                miscompares++;
                $display("FAIL %s u%0d: got %b want %b (wave,pd,busy,done) t=%0t",
                         name, u, got, want, $time);
            end
        end
    endtask

    // Monitor: outputs settle just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                exp_t x;
                x = sbq.pop_front();
                check(x.name, 0, {bus0.wave_out, bus0.period_done, bus0.busy, bus0.done}, x.e0, x.k0);
                check(x.name, 1, {bus1.wave_out, bus1.period_done, bus1.busy, bus1.done}, x.e1, x.k1);
            end
        end
    end

    task automatic tick(input logic [3:0] e0, input logic [3:0] k0,
                        input logic [3:0] e1, input logic [3:0] k1);
        exp_t x;
        x.name = tag;
        x.e0 = e0; x.k0 = k0; x.e1 = e1; x.k1 = k1;
        sbq.push_back(x);
        @(negedge clk);
    endtask

    task automatic t0(input logic [3:0] e);
        tick(e, 4'hF, 4'h0, 4'hF);
    endtask

    task automatic t1(input logic [3:0] e);
        tick(4'h0, 4'hF, e, 4'hF);
    endtask

    initial begin
        rst = 1'b0;
        bus0.en = 1'b0; bus0.load = 1'b0; bus0.m = '0; bus0.n = '0; bus0.burst_len = '0;
        bus1.en = 1'b0; bus1.load = 1'b0; bus1.m = '0; bus1.n = '0; bus1.burst_len = '0;
        @(negedge clk);
        t0(4'b0000);
        t0(4'b0000);
        rst = 1'b1;

        // m=3, n=2, no prescale
        tag = "pattern_3_2";
        bus0.load = 1'b1; bus0.m = 8'd3; bus0.n = 8'd2; t0(4'b0000);
        bus0.load = 1'b0; bus0.en = 1'b1;
        for (int i = 0; i < 15; i++) t0({(i % 5) < 3, (i % 5) == 4, 1'b1, 1'b0});
        bus0.en = 1'b0; t0(4'b0000); t0(4'b0000);

        // PRESCALE=4, m=2, n=1, reload m=1,n=1 mid-HIGH
        tag = "prescale4_reload";
        bus1.load = 1'b1; bus1.m = 8'd2; bus1.n = 8'd1; t1(4'b0000);
        bus1.load = 1'b0; bus1.en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            if (j == 3) begin
                bus1.load = 1'b1; bus1.m = 8'd1; bus1.n = 8'd1;
            end else begin
                bus1.load = 1'b0;
            end
            t1({(j < 8) || (j >= 12 && j < 16), (j == 11) || (j == 19), 1'b1, 1'b0});
        end
        bus1.en = 1'b0; t1(4'b0000);

        // m=n=0 holds idle with en high
        tag = "zero_zero";
        bus0.load = 1'b1; bus0.m = 8'd0; bus0.n = 8'd0; t0(4'b0000);
        bus0.load = 1'b0; bus0.en = 1'b1;
        for (int j = 0; j < 6; j++) t0(4'b0000);

        // m=5, n=0: constant high
        tag = "const_high";
        bus0.en = 1'b0; bus0.load = 1'b1; bus0.m = 8'd5; bus0.n = 8'd0; t0(4'b0000);
        bus0.load = 1'b0; bus0.en = 1'b1;
        for (int j = 0; j < 15; j++) t0({1'b1, (j % 5) == 4, 1'b1, 1'b0});
        bus0.en = 1'b0; t0(4'b0000);

        // m=0, n=3: constant low
        tag = "const_low";
        bus0.load = 1'b1; bus0.m = 8'd0; bus0.n = 8'd3; t0(4'b0000);
        bus0.load = 1'b0; bus0.en = 1'b1;
        for (int j = 0; j < 6; j++) t0({1'b0, (j % 3) == 2, 1'b1, 1'b0});
        bus0.en = 1'b0; t0(4'b0000);

        // en dropped on 2nd HIGH cycle: period completes
        tag = "stop_mid";
        bus0.load = 1'b1; bus0.m = 8'd4; bus0.n = 8'd4; t0(4'b0000);
        bus0.load = 1'b0; bus0.en = 1'b1; t0(4'b1010);
        bus0.en = 1'b0;
        for (int j = 1; j < 8; j++) t0({j < 4, j == 7, 1'b1, 1'b0});
        t0(4'b0000); t0(4'b0000);

        // Reset mid-LOW, then en held high with cleared settings
        tag = "reset_mid_low";
        bus1.load = 1'b1; bus1.m = 8'd1; bus1.n = 8'd1; t1(4'b0000);
        bus1.load = 1'b0; bus1.en = 1'b1;
        for (int j = 0; j < 6; j++) t1({j < 4, 1'b0, 1'b1, 1'b0});
        rst = 1'b0; t1(4'b0000);
        rst = 1'b1;
        for (int j = 0; j < 5; j++) t1(4'b0000);
        tag = "restart_after_reset";
        bus1.en = 1'b0; bus1.load = 1'b1; t1(4'b0000);
        bus1.load = 1'b0; bus1.en = 1'b1;
        for (int j = 0; j < 8; j++) t1({j < 4, j == 7, 1'b1, 1'b0});
        bus1.en = 1'b0; t1(4'b0000);

        // Burst of 3 periods; burst_len changed after start must not matter
        tag = "burst3";
        bus0.load = 1'b1; bus0.m = 8'd2; bus0.n = 8'd2; bus0.burst_len = 8'd3; t0(4'b0000);
        bus0.load = 1'b0; bus0.en = 1'b1;
`ifdef SQRWAV_BURST_EN
        for (int j = 0; j < 12; j++) begin
            t0({(j % 4) < 2, (j % 4) == 3, 1'b1, 1'b0});
            bus0.burst_len = 8'd0;
        end
        t0(4'b0001); t0(4'b0001); t0(4'b0001);
        bus0.en = 1'b0; t0(4'b0000); t0(4'b0000);
`else
        for (int j = 0; j < 16; j++) begin
            t0({(j % 4) < 2, (j % 4) == 3, 1'b1, 1'b0});
            bus0.burst_len = 8'd0;
        end
        bus0.en = 1'b0; t0(4'b0000); t0(4'b0000);
`endif

        @(posedge clk);
        #2;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
